// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC request arbiter: data width, default
// datapath latency, controller state encoding and a small sizing helper.
package cordic_pkg;

  localparam int DATA_W          = 32;
  localparam int LATENCY_DEFAULT = 17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cordic_arbiter_if.sv
// Requester, datapath and response signals of the CORDIC arbiter, bundled so
// the arbiter (slave) and its environment (master) share one definition.
interface cordic_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = cordic_pkg::DATA_W
);
  import cordic_pkg::*;

  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ*DATA_W-1:0] req_data_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic                    dp_valid_o;
  logic [DATA_W-1:0]       dp_data_o;
  logic [DATA_W-1:0]       dp_data_i;
  logic [N_REQ-1:0]        rsp_valid_o;
  logic [DATA_W-1:0]       rsp_data_o;

  modport slave (
    input  req_valid_i, req_data_i, dp_data_i,
    output req_ready_o, dp_valid_o, dp_data_o, rsp_valid_o, rsp_data_o
  );

  modport master (
    output req_valid_i, req_data_i, dp_data_i,
    input  req_ready_o, dp_valid_o, dp_data_o, rsp_valid_o, rsp_data_o
  );

endinterface

// File: rtl/cordic_tag_pipe.sv
// LATENCY-deep shift register of {valid, requester index} that travels
// alongside each operand so its result can be routed back to the owner.
module cordic_tag_pipe #(
  parameter int LATENCY = cordic_pkg::LATENCY_DEFAULT,
  parameter int IDX_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [IDX_W-1:0] in_idx_i,
  output logic             out_valid_o,
  output logic [IDX_W-1:0] out_idx_o
);

  logic [LATENCY-1:0] valid_q;
  logic [IDX_W-1:0]   idx_q [LATENCY];

  // NOTE: the index stages are reset along with the valid bits so the whole
  // pipe is defined after reset; only the valid bits are functionally needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) idx_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid_i;
      idx_q[0]   <= in_idx_i;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        idx_q[i]   <= idx_q[i-1];
      end
    end
  end

  assign out_valid_o = valid_q[LATENCY-1];
  assign out_idx_o   = idx_q[LATENCY-1];

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin arbiter sharing one fixed-latency CORDIC datapath among N_REQ
// requesters; results are routed back to their owner in acceptance order.
module cordic_arbiter #(
  parameter int N_REQ   = 4,
  parameter int LATENCY = cordic_pkg::LATENCY_DEFAULT,
  parameter int DATA_W  = cordic_pkg::DATA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable_i,
  cordic_arbiter_if.slave              bus,
  output logic                         busy_o,
  output logic [$clog2(LATENCY+2)-1:0] inflight_o
);
  import cordic_pkg::*;

  localparam int IW = idx_width(N_REQ);
  localparam int CW = $clog2(LATENCY + 2);

  state_e            state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic              dp_valid_q;
  logic [DATA_W-1:0] dp_data_q, dp_data_d;
  logic [IW-1:0]     dp_idx_q;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic              grant_allow;
  logic              found;
  logic [IW-1:0]     grant_idx;
  logic [N_REQ-1:0]  grant;
  logic              accept;
  logic              tag_valid;
  logic [IW-1:0]     tag_idx;

  assign grant_allow = enable_i && (state_q != DRAIN);

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    int            cand;
    logic [IW-1:0] cand_idx;
    found     = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand     = (int'(rr_ptr_q) + k) % N_REQ;
      cand_idx = IW'(cand);
      if (!found && bus.req_valid_i[cand_idx]) begin
        found     = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  assign accept = found && grant_allow;

  always_comb begin
    grant     = '0;
    dp_data_d = dp_data_q;
    for (int k = 0; k < N_REQ; k++) begin
      if (accept && (grant_idx == IW'(k))) begin
        grant[k]  = 1'b1;
        dp_data_d = bus.req_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  // Accept and response on the same edge cancel out.
  always_comb begin
    inflight_d = inflight_q;
    if (accept && !tag_valid)      inflight_d = inflight_q + CW'(1);
    else if (!accept && tag_valid) inflight_d = inflight_q - CW'(1);
  end

  always_comb begin
    rsp_data_d = rsp_data_q;
    for (int k = 0; k < N_REQ; k++) rsp_valid_d[k] = tag_valid && (tag_idx == IW'(k));
    if (tag_valid) rsp_data_d = bus.dp_data_i;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (inflight_d == '0) state_d = IDLE;
               else if (!enable_i)   state_d = DRAIN;
      DRAIN:   if (inflight_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      inflight_q  <= '0;
      dp_valid_q  <= 1'b0;
      dp_data_q   <= '0;
      dp_idx_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      inflight_q  <= inflight_d;
      dp_valid_q  <= accept;
      dp_data_q   <= dp_data_d;
      dp_idx_q    <= accept ? grant_idx : dp_idx_q;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Fed from the registered issue so the last stage lines up with the
  // datapath result arriving LATENCY cycles after dp_valid_o.
  cordic_tag_pipe #(
    .LATENCY (LATENCY),
    .IDX_W   (IW)
  ) u_tag_pipe (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (dp_valid_q),
    .in_idx_i    (dp_idx_q),
    .out_valid_o (tag_valid),
    .out_idx_o   (tag_idx)
  );

  assign bus.req_ready_o = grant;
  assign bus.dp_valid_o  = dp_valid_q;
  assign bus.dp_data_o   = dp_data_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_data_o  = rsp_data_q;
  assign busy_o          = (state_q != IDLE);
  assign inflight_o      = inflight_q;

endmodule

// File: doc/cordic_arbiter.md
CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the single CORDIC datapath.
REQ-002 Parameter LATENCY, default 17, fixed datapath latency in cycles from dp_data_o to dp_data_i.
REQ-003 Parameter DATA_W, default 32, IEEE-754 single-precision operand/result width.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 enable_i  input  1  high permits new grants; low stops grants and drains in-flight work.
REQ-007 req_valid_i  input  N_REQ  per-requester operand valid.
REQ-008 req_data_i  input  N_REQ*DATA_W  per-requester operand, requester i at bits [i*DATA_W +: DATA_W].
REQ-009 req_ready_o  output  N_REQ  one-hot grant; transfer when req_valid_i[i] and req_ready_o[i] are both high.
REQ-010 dp_valid_o  output  1  registered; operand on dp_data_o is live.
REQ-011 dp_data_o  output  DATA_W  registered operand to the datapath.
REQ-012 dp_data_i  input  DATA_W  datapath result.
REQ-013 rsp_valid_o  output  N_REQ  registered one-cycle pulse on the owning requester's bit; no backpressure.
REQ-014 rsp_data_o  output  DATA_W  registered result, valid only while any rsp_valid_o bit is high.
REQ-015 busy_o  output  1  high when state is not IDLE.
REQ-016 inflight_o  output  clog2(LATENCY+2)  count of accepted operands whose response has not yet been issued.

Function
REQ-017 Arbitration: round-robin; grant the lowest index at or above rr_ptr (modulo N_REQ) with req_valid_i high; at most one grant per cycle.
REQ-018 req_ready_o is combinational from req_valid_i, rr_ptr, state and enable_i; it is all-zero when enable_i is low or state is DRAIN.
REQ-019 On transfer of requester g, rr_ptr becomes (g+1) mod N_REQ at that edge; with no transfer, rr_ptr holds.
REQ-020 Issue: the edge accepting requester g loads dp_data_o with its operand and sets dp_valid_o for exactly one cycle; otherwise dp_valid_o is 0 and dp_data_o holds.
REQ-021 Tag pipe: a LATENCY-stage shift of {valid, index} is aligned with dp_valid_o; when the last stage is valid, the next edge loads rsp_data_o from dp_data_i and pulses rsp_valid_o[index].
REQ-022 Latency: rsp_valid_o rises exactly LATENCY+1 edges after the accepting edge; back-to-back accepts yield back-to-back responses in acceptance order.
REQ-023 inflight_o increments on accept, decrements on response issue, and holds when both occur on the same edge; it never exceeds LATENCY+1.
REQ-024 FSM IDLE: enter RUN on accept.
REQ-025 FSM RUN: enter DRAIN when enable_i is low and inflight_o is nonzero; enter IDLE when inflight_o is zero after the edge.
REQ-026 FSM DRAIN: no grants; enter IDLE on the edge where inflight_o reaches zero, including the case where enable_i re-rises in the same cycle.
REQ-027 A requester dropping req_valid_i before a grant is legal and loses no state; rr_ptr is unaffected.

Reset
REQ-028 rst is asynchronous, active-high: state=IDLE, rr_ptr=0, tag pipe cleared, inflight_o=0, dp_valid_o=0, dp_data_o=0, rsp_valid_o=0, rsp_data_o=0, busy_o=0.
REQ-029 Reset mid-operation discards all in-flight tags; no rsp_valid_o pulse follows for operands accepted before reset.

Structure
REQ-030 Shared package cordic_pkg holds DATA_W, the LATENCY default and the state enum {IDLE, RUN, DRAIN}.
REQ-031 Sub-module cordic_tag_pipe implements the LATENCY-deep {valid, index} shift register.
REQ-032 No arithmetic on operand data is performed; the datapath (float-to-fixed, CORDIC, fixed-to-float) is external.

Verification
REQ-033 Single request: req 0 with 0x3F000000 accepted at edge t -> dp_valid_o high for cycle t+1; rsp_valid_o = 0001 at edge t+18 with rsp_data_o equal to the dp_data_i model result.
REQ-034 All four requesters valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3; responses in the same order, one per cycle.
REQ-035 Only requesters 1 and 3 valid with rr_ptr=2 -> grant 3, then 1.
REQ-036 Accept 5 operands, then drop enable_i -> state DRAIN, req_ready_o=0, 5 responses issued, then IDLE with busy_o=0 and inflight_o=0.
REQ-037 Assert rst with 6 in flight -> all outputs at reset values immediately; no rsp_valid_o pulses appear over the next 20 cycles.
REQ-038 Simultaneous accept and response on one edge -> inflight_o unchanged.
